// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for the inter-stage pipeline register: mode selection,
// stall levels and the per-cycle action decode used in stall-vector mode.
package pipe_stage_reg_pkg;

  localparam int PIPE_MODE_STALL = 0;
  localparam int PIPE_MODE_HS    = 1;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } stall_act_e;

  // A stalled stage only injects a bubble when the stage after it is moving;
  // if the next stage is also stopped the whole register simply holds.
  function automatic stall_act_e decode_stall(input logic flush,
                                              input logic stall_cur,
                                              input logic stall_next);
    if (flush) return ACT_FLUSH;
    if (stall_cur == NO_STOP) return ACT_ADVANCE;
    if (stall_next == NO_STOP) return ACT_BUBBLE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// One-entry skid buffer: catches the payload accepted in the cycle the
// downstream side stops, so the upstream ready can be a plain register.
module pipe_skid_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] in_data,
  output logic         full,
  output logic [W-1:0] data
);

  logic         vld_p0;
  logic [W-1:0] data_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0 <= 1'b1;
    end else if (unload) begin
      vld_p0 <= 1'b0;
    end
  end

  // Payload is only meaningful while vld_p0 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      data_p0 <= in_data;
    end
  end

  assign full = vld_p0;
  assign data = data_p0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall-vector or valid/ready
// (skid-buffered) operation, synchronous flush and a saturating bubble counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                SIDE_W    = 1,
  parameter int                MODE      = 0,
  parameter int                STALL_W   = 6,
  parameter int                STAGE     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter logic [SIDE_W-1:0] SIDE_RST  = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [SIDE_W-1:0] side_p1;
  logic              bubble_evt;
  logic [CNT_W-1:0]  cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  generate
    if (MODE == PIPE_MODE_STALL) begin : g_stall
      stall_act_e act;
      logic       unused_m0;

      assign act        = decode_stall(flush, stall[STAGE], stall[STAGE+1]);
      assign in_ready   = (stall[STAGE] == NO_STOP);
      assign bubble_evt = (act == ACT_BUBBLE);
      assign unused_m0  = ^{out_ready, stall};

      // Stage boundary: upstream payload -> registered stage output.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= NOP_VALUE;
          side_p1 <= SIDE_RST;
        end else begin
          case (act)
            ACT_FLUSH: begin
              vld_p1  <= 1'b0;
              data_p1 <= NOP_VALUE;
              side_p1 <= SIDE_RST;
            end
            ACT_ADVANCE: begin
              vld_p1  <= in_valid;
              data_p1 <= in_data;
              side_p1 <= in_side;
            end
            ACT_BUBBLE: begin
              vld_p1  <= 1'b0;
              data_p1 <= NOP_VALUE;
            end
            default: begin
            end
          endcase
        end
      end
    end else begin : g_hs
      logic                     skid_full;
      logic                     skid_load;
      logic                     skid_unload;
      logic                     take_in;
      logic                     take_out;
      logic [DATA_W+SIDE_W-1:0] skid_q;
      logic                     unused_m1;

      assign in_ready    = ~skid_full;
      assign take_in     = in_valid & in_ready;
      assign take_out    = vld_p1 & out_ready;
      assign skid_load   = ~flush & take_in & vld_p1 & ~out_ready;
      assign skid_unload = ~flush & out_ready & skid_full;
      assign bubble_evt  = ~flush & ~vld_p1 & ~in_valid & out_ready;
      assign unused_m1   = ^stall;

      pipe_skid_buf #(
        .W(DATA_W + SIDE_W)
      ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .in_data({in_side, in_data}),
        .full   (skid_full),
        .data   (skid_q)
      );

      // Stage boundary: skid or upstream payload -> main output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= NOP_VALUE;
          side_p1 <= SIDE_RST;
        end else if (flush) begin
          vld_p1  <= 1'b0;
          data_p1 <= NOP_VALUE;
          side_p1 <= SIDE_RST;
        end else if (take_out && skid_full) begin
          vld_p1             <= 1'b1;
          {side_p1, data_p1} <= skid_q;
        end else if (take_in && (!vld_p1 || out_ready)) begin
          vld_p1  <= 1'b1;
          data_p1 <= in_data;
          side_p1 <= in_side;
        end else if (take_out) begin
          vld_p1  <= 1'b0;
          data_p1 <= NOP_VALUE;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (bubble_evt) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_side   = side_p1;
  assign bubble_cnt = cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stall-vector, saturating-counter and
// valid/ready-with-skid instances driven by directed vectors.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [5:0]  s0_stall;
  logic        s0_flush, s0_in_valid, s0_in_ready, s0_in_side;
  logic        s0_out_valid, s0_out_ready, s0_out_side;
  logic [15:0] s0_in_data, s0_out_data, s0_cnt;

  logic [5:0]  s4_stall;
  logic        s4_flush, s4_in_valid, s4_in_ready, s4_in_side;
  logic        s4_out_valid, s4_out_ready, s4_out_side;
  logic [15:0] s4_in_data, s4_out_data;
  logic [3:0]  s4_cnt;

  logic [5:0]  h_stall;
  logic        h_flush, h_in_valid, h_in_ready, h_in_side;
  logic        h_out_valid, h_out_ready, h_out_side;
  logic [15:0] h_in_data, h_out_data, h_cnt;

  pipe_stage_reg #(.DATA_W(16), .SIDE_W(1), .MODE(0), .STALL_W(6), .STAGE(2),
                   .NOP_VALUE(16'h0000), .SIDE_RST(1'b0), .CNT_W(16)) u_m0 (
    .clk(clk), .rst(rst), .stall(s0_stall), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .in_side(s0_in_side), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_data(s0_out_data), .out_side(s0_out_side), .bubble_cnt(s0_cnt));

  pipe_stage_reg #(.DATA_W(16), .SIDE_W(1), .MODE(0), .STALL_W(6), .STAGE(2),
                   .NOP_VALUE(16'h0000), .SIDE_RST(1'b0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall(s4_stall), .flush(s4_flush),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data),
    .in_side(s4_in_side), .out_valid(s4_out_valid), .out_ready(s4_out_ready),
    .out_data(s4_out_data), .out_side(s4_out_side), .bubble_cnt(s4_cnt));

  pipe_stage_reg #(.DATA_W(16), .SIDE_W(1), .MODE(1), .STALL_W(6), .STAGE(2),
                   .NOP_VALUE(16'h0000), .SIDE_RST(1'b0), .CNT_W(16)) u_m1 (
    .clk(clk), .rst(rst), .stall(h_stall), .flush(h_flush),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .in_side(h_in_side), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_data(h_out_data), .out_side(h_out_side), .bubble_cnt(h_cnt));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          inst;
    logic        vld;
    logic [15:0] data;
    logic        side;
    logic [15:0] cnt;
  } exp0_t;

  exp0_t       q0[$];
  logic [15:0] q1[$];

  logic track = 1'b0;
  logic prev_rdy = 1'b1;
  int   drops = 0, vcyc = 0, xfers = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one stall-mode cycle and queue the state expected after the edge.
  task automatic step0(input int inst, input logic [5:0] st, input logic fl,
                       input logic v, input logic [15:0] d, input logic s,
                       input logic ev, input logic [15:0] ed, input logic es,
                       input logic [15:0] ec);
    exp0_t e;
    logic  want_rdy;
    logic  got_rdy;
    if (inst == 0) begin
      s0_stall = st; s0_flush = fl; s0_in_valid = v; s0_in_data = d; s0_in_side = s;
    end else begin
      s4_stall = st; s4_flush = fl; s4_in_valid = v; s4_in_data = d; s4_in_side = s;
    end
    #1;
    want_rdy = ~st[2];
    got_rdy  = (inst == 0) ? s0_in_ready : s4_in_ready;
    chk((inst == 0) ? "m0_in_ready" : "sat_in_ready", {31'd0, got_rdy}, {31'd0, want_rdy});
    @(posedge clk); #1;
    e.inst = inst; e.vld = ev; e.data = ed; e.side = es; e.cnt = ec;
    q0.push_back(e);
  endtask

  initial begin : mon0
    exp0_t e;
    forever begin
      @(negedge clk);
      while (q0.size() > 0) begin
        e = q0.pop_front();
        if (e.inst == 0) begin
          chk("m0_out_valid", {31'd0, s0_out_valid}, {31'd0, e.vld});
          chk("m0_out_data",  {16'd0, s0_out_data},  {16'd0, e.data});
          chk("m0_out_side",  {31'd0, s0_out_side},  {31'd0, e.side});
          chk("m0_bubble_cnt", {16'd0, s0_cnt},      {16'd0, e.cnt});
        end else begin
          chk("sat_out_valid", {31'd0, s4_out_valid}, {31'd0, e.vld});
          chk("sat_out_data",  {16'd0, s4_out_data},  {16'd0, e.data});
          chk("sat_bubble_cnt", {28'd0, s4_cnt},      {16'd0, e.cnt});
        end
      end
    end
  end

  initial begin : mon1
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (h_out_valid && h_out_ready) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL m1_unexpected_out: got %0h want none", h_out_data);
        end else begin
          e = q1.pop_front();
          chk("m1_out_data", {16'd0, h_out_data}, {16'd0, e});
        end
      end
      if (!h_out_valid && !rst) chk("m1_nop_when_idle", {16'd0, h_out_data}, 32'd0);
      if (track) begin
        if (prev_rdy && !h_in_ready) drops++;
        if (h_out_valid) vcyc++;
        if (h_out_valid && h_out_ready) xfers++;
      end
      prev_rdy = h_in_ready;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int  idx;
    int  c;
    logic acc;
    rst = 1'b1;
    s0_stall = '0; s0_flush = 0; s0_in_valid = 0; s0_in_data = '0; s0_in_side = 0; s0_out_ready = 1;
    s4_stall = '0; s4_flush = 0; s4_in_valid = 0; s4_in_data = '0; s4_in_side = 0; s4_out_ready = 1;
    h_stall = '0; h_flush = 0; h_in_valid = 0; h_in_data = '0; h_in_side = 0; h_out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Load some state, then reset asynchronously between edges.
    step0(0, 6'b000000, 0, 1, 16'h0FF0, 1, 1, 16'h0FF0, 1, 16'd0);
    step0(0, 6'b000100, 0, 1, 16'h0BAD, 0, 0, 16'h0000, 1, 16'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, s0_out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, s0_out_data},  32'd0);
    chk("rst_out_side",  {31'd0, s0_out_side},  32'd0);
    chk("rst_bubble_cnt", {16'd0, s0_cnt},      32'd0);
    chk("rst_m1_in_ready", {31'd0, h_in_ready}, 32'd1);
    chk("rst_m1_out_valid", {31'd0, h_out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Bubble keeps the sideband.
    step0(0, 6'b000000, 0, 1, 16'h1111, 1, 1, 16'h1111, 1, 16'd0);
    step0(0, 6'b000100, 0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'd1);
    // Hold for three cycles, then advance.
    for (int k = 0; k < 3; k++)
      step0(0, 6'b001100, 0, 1, 16'h9999, 0, 0, 16'h0000, 1, 16'd1);
    step0(0, 6'b000000, 0, 1, 16'hABCD, 0, 1, 16'hABCD, 0, 16'd1);
    for (int k = 0; k < 2; k++)
      step0(0, 6'b001100, 0, 1, 16'h7777, 1, 1, 16'hABCD, 0, 16'd1);
    step0(0, 6'b000100, 0, 1, 16'h7777, 1, 0, 16'h0000, 0, 16'd2);
    step0(0, 6'b000000, 0, 1, 16'h2222, 1, 1, 16'h2222, 1, 16'd2);
    // Flush wins over advance and over bubble, and is not counted.
    step0(0, 6'b000000, 1, 1, 16'h5555, 1, 0, 16'h0000, 0, 16'd2);
    step0(0, 6'b000000, 0, 1, 16'h3333, 1, 1, 16'h3333, 1, 16'd2);
    step0(0, 6'b000100, 1, 1, 16'h4444, 1, 0, 16'h0000, 0, 16'd2);

    // Saturation on a 4-bit counter.
    for (int k = 1; k <= 20; k++)
      step0(1, 6'b000100, 0, 1, 16'h00F0, 0, 0, 16'h0000, 0, (k > 15) ? 16'd15 : 16'(k));
    step0(1, 6'b000000, 0, 1, 16'h3C3C, 1, 1, 16'h3C3C, 1, 16'd15);
    @(negedge clk);

    // Valid/ready stream 1..8 with out_ready low on cycles 3 and 4.
    track = 1'b1; idx = 0; c = 0;
    while ((idx < 8 || q1.size() > 0) && c < 40) begin
      h_out_ready = (c != 3 && c != 4);
      h_in_valid  = (idx < 8);
      h_in_data   = 16'(idx + 1);
      acc = h_in_valid && h_in_ready;
      if (acc) q1.push_back(16'(idx + 1));
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    track = 1'b0; h_in_valid = 0; h_out_ready = 0;
    chk("m1_stream_done", {31'd0, (idx == 8 && q1.size() == 0)}, 32'd1);
    chk("m1_in_ready_drops", 32'(drops), 32'd1);
    chk("m1_transfers", 32'(xfers), 32'd8);
    chk("m1_valid_cycles_no_gaps", 32'(vcyc), 32'd10);
    chk("m1_cnt_after_stream", {16'd0, h_cnt}, 32'd0);

    // Idle cycles count only while out_ready is high.
    h_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 h_out_ready = 0;
    chk("m1_cnt_idle_ready", {16'd0, h_cnt}, 32'd3);
    repeat (2) @(posedge clk);
    #1 chk("m1_cnt_idle_not_ready", {16'd0, h_cnt}, 32'd3);

    // Fill main and skid, then flush while offering another payload.
    h_in_valid = 1; h_in_data = 16'h00A1;
    @(posedge clk); #1 h_in_data = 16'h00A2;
    @(posedge clk); #1 h_in_valid = 0;
    chk("m1_full_out_valid", {31'd0, h_out_valid}, 32'd1);
    chk("m1_full_out_data", {16'd0, h_out_data}, 32'h00A1);
    chk("m1_full_in_ready", {31'd0, h_in_ready}, 32'd0);
    h_flush = 1; h_in_valid = 1; h_in_data = 16'h00A3;
    #1 chk("m1_flush_cycle_in_ready", {31'd0, h_in_ready}, 32'd0);
    @(posedge clk); #1 h_flush = 0; h_in_valid = 0;
    chk("m1_flush_out_valid", {31'd0, h_out_valid}, 32'd0);
    chk("m1_flush_in_ready", {31'd0, h_in_ready}, 32'd1);
    chk("m1_flush_out_data", {16'd0, h_out_data}, 32'd0);
    chk("m1_flush_cnt", {16'd0, h_cnt}, 32'd3);

    // Stage must restart cleanly with nothing from before the flush.
    h_out_ready = 1; h_in_valid = 1; h_in_data = 16'h0055;
    q1.push_back(16'h0055);
    @(posedge clk); #1 h_in_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("m1_post_flush_drained", 32'(q1.size()), 32'd0);
    h_out_ready = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
